// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and pixel/coordinate types for the VGA scan path.
// Also used by the colour chooser (BACKGROUND).
package vga_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Asserted level of hsync/vsync; 0 means active-low.
   localparam logic VGA_SYNC_POL = 1'b0;

   typedef logic [11:0]        color_t;
   typedef logic signed [10:0] coord_t;

   localparam color_t BACKGROUND = 12'h000;

   function automatic logic [10:0] cnt11(input int unsigned v);
      return v[10:0];
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping counter plus decoded active-region and sync-window flags.
// Instantiated once per axis by vga_sync_driver.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned TOTAL      = 800,
   parameter int unsigned SYNC_START = 656,
   parameter int unsigned SYNC_LEN   = 96,
   parameter int unsigned ACTIVE     = 640
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [10:0] count,
   output logic        wrap,
   output logic        active,
   output logic        sync
);

   localparam logic [10:0] LastCnt   = cnt11(TOTAL - 1);
   localparam logic [10:0] ActiveCnt = cnt11(ACTIVE);
   localparam logic [10:0] SyncFirst = cnt11(SYNC_START);
   localparam logic [10:0] SyncLast  = cnt11(SYNC_START + SYNC_LEN - 1);

   logic [10:0] count_q, count_d;

   always_comb begin
      wrap    = (count_q == LastCnt);
      count_d = count_q;
      if (en) begin
         count_d = wrap ? '0 : count_q + 11'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign active = (count_q < ActiveCnt);
   assign sync   = (count_q >= SyncFirst) && (count_q <= SyncLast);

endmodule

// File: rtl/vga_sync_driver.sv
// VGA scan generator: exports scan coordinates, registers returned colour and syncs to the DAC.
// Define PIXEL_DIV_EN when clk is 100 MHz to derive the 25 MHz pixel enable internally.
module vga_sync_driver
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        SYNC_POL = VGA_SYNC_POL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [11:0]        PIX_COLOR,
   output logic signed [10:0] x_VGA,
   output logic signed [10:0] y_VGA,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_tick
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] VActiveCnt = cnt11(V_ACTIVE);

   logic        pix_en, v_en;
   logic [10:0] h_cnt, v_cnt;
   logic        h_wrap, unused_v_wrap;
   logic        h_active, v_active, h_sync, v_sync;

`ifdef PIXEL_DIV_EN
   logic [1:0] div_q;

   // First enable lands on the 4th clk after reset release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 2'd1;
      end
   end

   assign pix_en = (div_q == 2'd3);
`else
   assign pix_en = 1'b1;
`endif

   assign v_en = pix_en & h_wrap;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_LEN   (H_SYNC),
      .ACTIVE     (H_ACTIVE)
   ) u_h (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (pix_en),
      .count  (h_cnt),
      .wrap   (h_wrap),
      .active (h_active),
      .sync   (h_sync)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_LEN   (V_SYNC),
      .ACTIVE     (V_ACTIVE)
   ) u_v (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (v_en),
      .count  (v_cnt),
      .wrap   (unused_v_wrap),
      .active (v_active),
      .sync   (v_sync)
   );

   color_t rgb_q, rgb_d;
   logic   hsync_q, hsync_d, vsync_q, vsync_d, tick_q, tick_d;

   // Colour and syncs share one register stage so they stay pixel-aligned at the DAC.
   always_comb begin
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      tick_d  = tick_q;
      if (pix_en) begin
         rgb_d   = (h_active && v_active) ? PIX_COLOR : '0;
         hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
         vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
         tick_d  = (h_cnt == '0) && (v_cnt == VActiveCnt);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb_q   <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         tick_q  <= 1'b0;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         tick_q  <= tick_d;
      end
   end

   assign x_VGA      = coord_t'(h_cnt);
   assign y_VGA      = coord_t'(v_cnt);
   assign vga_r      = rgb_q[11:8];
   assign vga_g      = rgb_q[7:4];
   assign vga_b      = rgb_q[3:0];
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sync_driver.sv
// Scoreboard bench: full 640x480 instance for line timing, plus a shrunk instance for frame timing.
module tb_vga_sync_driver;

`ifdef PIXEL_DIV_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   typedef struct packed {
      int   ha; int hfp; int hs; int hbp;
      int   va; int vfp; int vs; int vbp;
      logic pol;
   } timing_t;

   logic               clk, rst_n;
   logic [11:0]        pix_a, pix_b;
   logic signed [10:0] xa, ya, xb, yb;
   logic [3:0]         ra, ga, ba, rb, gb, bb;
   logic               hsa, vsa, fta, hsb, vsb, ftb;

   timing_t     ta, tt;
   logic [14:0] qa[$], qb[$];
   int          exa, eya, exb, eyb;
   int          n_total, n_bad;
   int          hs_low_line0, ticks_b, exp_ticks_b;
   logic        const_mode, count_en;

   vga_sync_driver u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .PIX_COLOR  (pix_a),
      .x_VGA      (xa),
      .y_VGA      (ya),
      .vga_r      (ra),
      .vga_g      (ga),
      .vga_b      (ba),
      .hsync      (hsa),
      .vsync      (vsa),
      .frame_tick (fta)
   );

   vga_sync_driver #(
      .H_ACTIVE (12), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
      .SYNC_POL (1'b1)
   ) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .PIX_COLOR  (pix_b),
      .x_VGA      (xb),
      .y_VGA      (yb),
      .vga_r      (rb),
      .vga_g      (gb),
      .vga_b      (bb),
      .hsync      (hsb),
      .vsync      (vsb),
      .frame_tick (ftb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [14:0] model(input timing_t t, input int x, input int y,
                                         input logic [11:0] c);
      logic on, hs, vs, tk;
      int   hs0, vs0;
      hs0 = t.ha + t.hfp;
      vs0 = t.va + t.vfp;
      on  = (x < t.ha) && (y < t.va);
      hs  = (x >= hs0 && x < hs0 + t.hs) ? t.pol : ~t.pol;
      vs  = (y >= vs0 && y < vs0 + t.vs) ? t.pol : ~t.pol;
      tk  = (x == 0) && (y == t.va);
      return {on ? c : 12'h000, hs, vs, tk};
   endfunction

   function automatic logic [11:0] pattern(input int x, input int y);
      return 12'(x * 37 + y * 101) ^ 12'h5A3;
   endfunction

   task automatic advance(input timing_t t, inout int x, inout int y);
      if (x == t.ha + t.hfp + t.hs + t.hbp - 1) begin
         x = 0;
         y = (y == t.va + t.vfp + t.vs + t.vbp - 1) ? 0 : y + 1;
      end else begin
         x = x + 1;
      end
   endtask

   task automatic model_reset();
      exa = 0; eya = 0; exb = 0; eyb = 0;
      qa.delete();
      qb.delete();
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_xy_a"}, 32'({xa, ya}), 32'd0);
      check_eq({tag, "_rgb_a"}, 32'({ra, ga, ba}), 32'd0);
      check_eq({tag, "_sync_a"}, 32'({hsa, vsa}), 32'b11);
      check_eq({tag, "_tick_a"}, 32'(fta), 32'd0);
      check_eq({tag, "_xy_b"}, 32'({xb, yb}), 32'd0);
      check_eq({tag, "_rgb_b"}, 32'({rb, gb, bb}), 32'd0);
      check_eq({tag, "_sync_b"}, 32'({hsb, vsb}), 32'b00);
      check_eq({tag, "_tick_b"}, 32'(ftb), 32'd0);
   endtask

   // One pixel period: present colour for the modelled coordinate, then compare one pixel later.
   task automatic step();
      logic [14:0] ea, eb;
      pix_a = const_mode ? 12'hF0A : pattern(exa, eya);
      pix_b = pattern(exb, eyb);
      qa.push_back(model(ta, exa, eya, pix_a));
      qb.push_back(model(tt, exb, eyb, pix_b));
`ifdef PIXEL_DIV_EN
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("x_hold", 32'({xa, ya}), 32'({11'(exa), 11'(eya)}));
      end
`endif
      @(posedge clk);
      #1;
      ea = qa.pop_front();
      eb = qb.pop_front();
      check_eq("out_a", 32'({ra, ga, ba, hsa, vsa, fta}), 32'(ea));
      check_eq("out_b", 32'({rb, gb, bb, hsb, vsb, ftb}), 32'(eb));
      if (count_en && eya == 0 && !hsa) hs_low_line0++;
      if (ftb) ticks_b++;
      if (eb[0]) exp_ticks_b++;
      advance(ta, exa, eya);
      advance(tt, exb, eyb);
      check_eq("xy_a", 32'({xa, ya}), 32'({11'(exa), 11'(eya)}));
      check_eq("xy_b", 32'({xb, yb}), 32'({11'(exb), 11'(eyb)}));
   endtask

   initial begin
      ta = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, pol: 1'b0};
      tt = '{ha: 12, hfp: 2, hs: 3, hbp: 3, va: 6, vfp: 2, vs: 2, vbp: 3, pol: 1'b1};
      n_total = 0; n_bad = 0;
      hs_low_line0 = 0; ticks_b = 0; exp_ticks_b = 0;
      pix_a = '0; pix_b = '0;
      rst_n = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Constant colour, first lines of the full-size scan up to (300,2).
      const_mode = 1'b1;
      count_en   = 1'b1;
      while (!(exa == 300 && eya == 2)) step();
      check_eq("hsync_low_line0", 32'(hs_low_line0), 32'd96);
      check_eq("ticks_b_p1", 32'(ticks_b), 32'(exp_ticks_b));

      // One-clk reset mid-line, then restart from (0,0).
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      const_mode  = 1'b0;
      count_en    = 1'b0;
      ticks_b     = 0;
      exp_ticks_b = 0;
      repeat (2400) step();
      check_eq("ticks_b_p2", 32'(ticks_b), 32'(exp_ticks_b));
      check_eq("ticks_b_frames", 32'(ticks_b), 32'(2400 / 260));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
